// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing,
// memory-hold freeze and a saturating bubble counter.
module idex_hazard_stage #(
  parameter int DW   = 32,
  parameter int CNTW = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            id_valid,
  input  logic [5:0]      id_op,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [DW-1:0]   id_rega,
  input  logic [DW-1:0]   id_regb,
  input  logic [DW-1:0]   id_imm,
  input  logic [7:0]      id_ctrl,
  input  logic            ex_flush,
  input  logic            mem_hold,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            idex_valid,
  output logic [5:0]      idex_op,
  output logic [4:0]      idex_rs,
  output logic [4:0]      idex_rt,
  output logic [4:0]      idex_dst,
  output logic [DW-1:0]   idex_rega,
  output logic [DW-1:0]   idex_regb,
  output logic [DW-1:0]   idex_imm,
  output logic [7:0]      idex_ctrl,
  output logic [CNTW-1:0] bubble_cnt
);

  // Control bit positions within {regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, jump}
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_REGDST   = 2;

  typedef enum logic {IDLE, PEND} flush_state_t;

  flush_state_t    r_flushState;
  logic            r_valid;
  logic [5:0]      r_op;
  logic [4:0]      r_rs;
  logic [4:0]      r_rt;
  logic [4:0]      r_dst;
  logic [DW-1:0]   r_rega;
  logic [DW-1:0]   r_regb;
  logic [DW-1:0]   r_imm;
  logic [7:0]      r_ctrl;
  logic [CNTW-1:0] r_bubbleCnt;

  logic            w_rtIsSource;
  logic            w_luh;
  logic [4:0]      w_dst;
  logic            w_flushNow;

  // rt is read as a source by R-type, branches and stores only
  always_comb begin
    w_rtIsSource = 1'b0;
    case (id_op)
      6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: w_rtIsSource = 1'b1;
      default:                                  w_rtIsSource = 1'b0;
    endcase
  end

  assign w_luh = r_valid & r_ctrl[CTRL_MEMREAD] & id_valid & (r_rt != 5'd0) &
                 ((r_rt == id_rs) | ((r_rt == id_rt) & w_rtIsSource));

  assign w_dst = id_ctrl[CTRL_REGWRITE] ? (id_ctrl[CTRL_REGDST] ? id_rd : id_rt) : 5'd0;

  assign w_flushNow = ex_flush | (r_flushState == PEND);

  assign pc_write   = ~w_luh & ~mem_hold;
  assign ifid_write = ~w_luh & ~mem_hold;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_flushState <= IDLE;
      r_valid      <= 1'b0;
      r_op         <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dst        <= '0;
      r_rega       <= '0;
      r_regb       <= '0;
      r_imm        <= '0;
      r_ctrl       <= '0;
      r_bubbleCnt  <= '0;
    end else if (mem_hold) begin
      // A flush arriving during a hold is remembered and applied on release
      if (ex_flush) r_flushState <= PEND;
    end else if (w_flushNow || w_luh) begin
      r_flushState <= IDLE;
      r_valid      <= 1'b0;
      r_op         <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dst        <= '0;
      r_rega       <= '0;
      r_regb       <= '0;
      r_imm        <= '0;
      r_ctrl       <= '0;
      if (!w_flushNow && (r_bubbleCnt != {CNTW{1'b1}}))
        r_bubbleCnt <= r_bubbleCnt + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      r_valid <= id_valid;
      r_op    <= id_op;
      r_rs    <= id_rs;
      r_rt    <= id_rt;
      r_rega  <= id_rega;
      r_regb  <= id_regb;
      r_imm   <= id_imm;
      r_ctrl  <= id_valid ? id_ctrl : 8'd0;
      r_dst   <= id_valid ? w_dst : 5'd0;
    end
  end

  assign idex_valid = r_valid;
  assign idex_op    = r_op;
  assign idex_rs    = r_rs;
  assign idex_rt    = r_rt;
  assign idex_dst   = r_dst;
  assign idex_rega  = r_rega;
  assign idex_regb  = r_regb;
  assign idex_imm   = r_imm;
  assign idex_ctrl  = r_ctrl;
  assign bubble_cnt = r_bubbleCnt;

endmodule

// File: doc/idex_hazard_stage.md
Name: idex_hazard_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection.
- Sits between decode and execute.
- Produces idex_rs/idex_rt/idex_dst, register operands and control bits, which the EX-stage forwarding logic and ALU consume.
- Inserts bubbles on load-use hazards, squashes on branch/jump flush, freezes on memory hold, and keeps a bubble-cycle performance counter.

Parameters:
- DW, 32, datapath width of register operands and immediate.
- CNTW, 32, width of the saturating bubble counter.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_op  in  6  opcode.
- id_rs, id_rt, id_rd  in  5 each  source and destination register fields.
- id_rega, id_regb  in  DW  register file read data.
- id_imm  in  DW  sign-extended immediate.
- id_ctrl  in  8  {regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, jump}.
- ex_flush  in  1  branch/jump resolved taken in EX; squash younger instructions.
- mem_hold  in  1  data memory not ready; freeze whole pipeline.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- idex_valid  out  1  EX holds a real instruction.
- idex_op  out  6  registered opcode.
- idex_rs, idex_rt  out  5 each  registered sources (to forwarding).
- idex_dst  out  5  write register: rd if regdst=1, else rt; forced 0 when regwrite=0.
- idex_rega, idex_regb, idex_imm  out  DW each  registered operands.
- idex_ctrl  out  8  registered control.
- bubble_cnt  out  CNTW  saturating count of inserted bubbles.

Behaviour:
- Reset (async, resetn=0): every idex_* output 0, bubble_cnt 0, flush_pend 0. pc_write=ifid_write=1 (combinational; no hazard while idex_valid=0).
- Load-use detect (combinational): luh = idex_valid & idex_ctrl.memread & id_valid & idex_rt!=0 & (idex_rt==id_rs | (idex_rt==id_rt & id_op uses rt as source)).
  - rt is a source for R-type (op 0), store and branch (beq/bne).
  - rt is not a source for loads or ALU-immediate ops.
- pc_write = ifid_write = ~luh & ~mem_hold.
- State: flush_pend register (2 states, IDLE/PEND).
  - mem_hold=1 and ex_flush=1 in the same cycle: enter PEND.
  - Leave PEND on the first edge with mem_hold=0; that edge applies the flush.
- Per rising edge, priority highest first:
  1. mem_hold=1: all ID/EX registers hold; bubble_cnt holds.
  2. ex_flush=1 or flush_pend=1: load bubble (idex_valid=0, idex_ctrl=0, idex_dst=0; other fields don't-care, drive 0); clear flush_pend. Not counted as a bubble.
  3. luh=1: load bubble; bubble_cnt += 1, saturating at all-ones.
  4. else: capture ID fields, with idex_valid=id_valid. If id_valid=0, also force ctrl=0 and dst=0.
- Latency: one cycle from ID inputs to idex_* outputs.
- A load-use stall lasts exactly one cycle, because the bubble clears idex_ctrl.memread.
- Back-to-back loads each with a dependent consumer stall once each.
- Register $0 never triggers a stall and is never a destination.
- Flush and luh together: flush wins and no bubble is counted. pc_write stays 0 that cycle; the IF/ID flush is the fetch stage's job.
- Reset mid-stall or mid-hold: everything returns to reset values immediately; flush_pend cleared.

Test Plan:
- Reset: assert resetn=0 mid-stream -> all idex_* outputs 0, bubble_cnt 0, pc_write=1 within the same cycle.
- Load-use stall:
  - Stimulus: lw $5 captured (memread=1, idex_rt=5), then id_rs=5 (add).
  - Response: pc_write=ifid_write=0 for exactly one cycle; next edge idex_valid=0, ctrl=0; bubble_cnt 0->1; the following edge captures the add with idex_rs=5.
- No false stall:
  - lw $0 followed by id_rs=0 -> no stall.
  - lw $5 followed by addi with id_rt=5 -> no stall.
  - lw $5 followed by sw with id_rt=5 -> stall.
- Flush: ex_flush=1 with a valid ID instruction -> next edge idex_valid=0, idex_dst=0; bubble_cnt unchanged.
- Hold with pending flush:
  - Stimulus: mem_hold=1 for 3 cycles, ex_flush pulsed on the first of them.
  - Response: outputs frozen for all 3 cycles; the first edge after release inserts the bubble; flush_pend returns to 0.
- Counter saturation: CNTW=4, 20 load-use stalls -> bubble_cnt sticks at 15.
